// File: rtl/ssa_pkg.sv
// Shared limb/product widths, controller state encoding and the partial-product shift rule
// for the shared-multiplier wide product sequencer.
package ssa_pkg;
  localparam int LIMB_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int prod_shift(input int i, input int j);
    return LIMB_W * (i + j);
  endfunction
endpackage

// File: rtl/ssa_pair_counter.sv
// Walks the limb pair (i, j) in row-major order, holding each pair for MUL_LAT+1 cycles.
// slot_last marks the final cycle of a slot; pair_last marks the final pair (LIMBS-1, LIMBS-1).
module ssa_pair_counter #(
  parameter int LIMBS   = 4,
  parameter int MUL_LAT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  output logic [2:0] i_idx,
  output logic [2:0] j_idx,
  output logic       slot_last,
  output logic       pair_last
);
  localparam logic [2:0] LAST_IDX  = 3'(LIMBS - 1);
  localparam logic [2:0] LAST_WAIT = 3'(MUL_LAT);

  logic [2:0] i_q, i_d;
  logic [2:0] j_q, j_d;
  logic [2:0] w_q, w_d;

  assign slot_last = (w_q == LAST_WAIT);
  assign pair_last = (i_q == LAST_IDX) && (j_q == LAST_IDX);
  assign i_idx     = i_q;
  assign j_idx     = j_q;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    w_d = w_q;
    if (clear) begin
      i_d = '0;
      j_d = '0;
      w_d = '0;
    end else if (en) begin
      if (!slot_last) begin
        w_d = w_q + 3'd1;
      end else begin
        w_d = '0;
        // j is the inner index; i only moves when j wraps
        if (j_q == LAST_IDX) begin
          j_d = '0;
          i_d = (i_q == LAST_IDX) ? 3'd0 : i_q + 3'd1;
        end else begin
          j_d = j_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      w_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      w_q <= w_d;
    end
  end
endmodule

// File: rtl/ssa_mult_sequencer.sv
// Wide schoolbook multiplier controller: feeds one limb pair per slot to an external 8x8 multiplier
// and accumulates shifted partial products; result is registered and held until the next product.
module ssa_mult_sequencer
  import ssa_pkg::*;
#(
  parameter int LIMBS   = 4,
  parameter int MUL_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*LIMBS-1:0]    a,
  input  logic [8*LIMBS-1:0]    b,
  output logic                  busy,
  output logic                  done,
  output logic [16*LIMBS-1:0]   result,
  output logic [7:0]            mul_a,
  output logic [7:0]            mul_b,
  input  logic [15:0]           mul_c
);
  localparam int OP_W  = LIMB_W * LIMBS;
  localparam int ACC_W = PROD_W * LIMBS;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [2:0]        i_idx, j_idx;
  logic              slot_last, pair_last;
  logic              cnt_clear, cnt_en;
  logic [OP_W-1:0]   a_sh, b_sh;
  logic [ACC_W-1:0]  pp;

  assign cnt_clear = (state_q == IDLE) && start;
  assign cnt_en    = (state_q == MUL);

  ssa_pair_counter #(
    .LIMBS   (LIMBS),
    .MUL_LAT (MUL_LAT)
  ) u_pair_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .en        (cnt_en),
    .i_idx     (i_idx),
    .j_idx     (j_idx),
    .slot_last (slot_last),
    .pair_last (pair_last)
  );

  // Limbs come from the latched operands only, so they stay put for the whole slot
  assign a_sh  = a_q >> (LIMB_W * int'(i_idx));
  assign b_sh  = b_q >> (LIMB_W * int'(j_idx));
  assign mul_a = a_sh[LIMB_W-1:0];
  assign mul_b = b_sh[LIMB_W-1:0];
  assign pp    = ACC_W'(mul_c) << prod_shift(int'(i_idx), int'(j_idx));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        if (slot_last) begin
          acc_d = acc_q + pp;
          if (pair_last) begin
            result_d = acc_q + pp;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_ssa_mult_sequencer.sv
// Bench for ssa_mult_sequencer: a combinational-multiplier instance and a MUL_LAT=2 instance
// with a two-stage registered multiplier, checked against plain 64-bit products.
module tb_ssa_mult_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] a = '0, b = '0;

  logic        busy0, done0, busy1, done1;
  logic [63:0] result0, result1;
  logic [7:0]  mul_a0, mul_b0, mul_a1, mul_b1;
  logic [15:0] mul_c0, mul_c1, pipe1, pipe2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssa_mult_sequencer #(.LIMBS(4), .MUL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a), .b(b),
    .busy(busy0), .done(done0), .result(result0),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_c(mul_c0)
  );

  ssa_mult_sequencer #(.LIMBS(4), .MUL_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(result1),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_c(mul_c1)
  );

  assign mul_c0 = {8'h00, mul_a0} * {8'h00, mul_b0};
  always @(posedge clk) begin
    pipe1 <= {8'h00, mul_a1} * {8'h00, mul_b1};
    pipe2 <= pipe1;
  end
  assign mul_c1 = pipe2;

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
    return 64'(x) * 64'(y);
  endfunction

  // Runs one operation starting from a negedge; optional extra start pulses in cycles inj1/inj2.
  // Returns latency (edges from acceptance to done), busy/done cycle counts, result seen with done,
  // and the number of cycles where mul_a/mul_b differed from the limbs of the slot in progress.
  task automatic run_op(input bit sel, input logic [31:0] aa, input logic [31:0] bb,
                        input int inj1, input int inj2,
                        input logic [31:0] alt_a, input logic [31:0] alt_b,
                        output int lat, output int busy_cnt, output int done_cnt,
                        output logic [63:0] res, output int limb_err);
    int lp, n, s;
    logic [31:0] ta, tb;
    logic bo, dn;
    logic [7:0] ma, mb;
    lp = sel ? 2 : 0;
    n = 16 * (lp + 1);
    lat = -1; busy_cnt = 0; done_cnt = 0; res = '0; limb_err = 0;
    a = aa; b = bb;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == inj1 || k == inj2) begin
        a = alt_a; b = alt_b;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      bo = sel ? busy1 : busy0;
      dn = sel ? done1 : done0;
      ma = sel ? mul_a1 : mul_a0;
      mb = sel ? mul_b1 : mul_b0;
      if (bo) busy_cnt++;
      if (dn) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k - 1;
          res = sel ? result1 : result0;
        end
      end
      if (k <= n) begin
        s = (k - 1) / (lp + 1);
        ta = aa >> (8 * (s / 4));
        tb = bb >> (8 * (s % 4));
        if (ma !== ta[7:0] || mb !== tb[7:0]) limb_err++;
      end
      if (lat >= 0 && !bo) break;
    end
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done0); end
    checks++; if (result0 !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", result0); end
    checks++; if (mul_a0 !== 8'h0 || mul_b0 !== 8'h0) begin errors++; $display("FAIL reset_mul got %h/%h want 0/0", mul_a0, mul_b0); end
    checks++; if (busy1 !== 1'b0 || result1 !== 64'h0) begin errors++; $display("FAIL reset_lat2 got busy %0b result %h want 0/0", busy1, result1); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc, dc, le;
    logic [63:0] res;
    run_op(1'b0, 32'd124, 32'd201, -1, -1, '0, '0, lat, bc, dc, res, le);
    checks++; if (lat !== 16) begin errors++; $display("FAIL basic_latency got %0d want 16", lat); end
    checks++; if (res !== 64'd24924) begin errors++; $display("FAIL basic_result got %h want %h", res, 64'd24924); end
    checks++; if (bc !== 17) begin errors++; $display("FAIL basic_busy_cycles got %0d want 17", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", dc); end
    checks++; if (le !== 0) begin errors++; $display("FAIL basic_limb_drive got %0d bad cycles want 0", le); end
    repeat (3) @(negedge clk);
    checks++; if (result0 !== 64'd24924) begin errors++; $display("FAIL basic_result_hold got %h want %h", result0, 64'd24924); end
  endtask

  task automatic test_extremes();
    int lat, bc, dc, le;
    logic [63:0] res;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, '0, '0, lat, bc, dc, res, le);
    checks++; if (res !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL max_result got %h want %h", res, 64'hFFFF_FFFE_0000_0001); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL max_done_pulses got %0d want 1", dc); end
    run_op(1'b0, 32'h1234_5678, 32'h0, -1, -1, '0, '0, lat, bc, dc, res, le);
    checks++; if (res !== 64'h0) begin errors++; $display("FAIL zero_result got %h want 0", res); end
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, -1, -1, '0, '0, lat, bc, dc, res, le);
    checks++; if (res !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL shift_result got %h want %h", res, 64'h0000_0001_0000_0000); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, dc, le;
    logic [63:0] res;
    run_op(1'b0, 32'h0000_1234, 32'h0000_5678, 3, 17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, dc, res, le);
    checks++; if (res !== ref_prod(32'h1234, 32'h5678)) begin errors++; $display("FAIL ignore_start_result got %h want %h", res, ref_prod(32'h1234, 32'h5678)); end
    checks++; if (dc !== 1 || bc !== 17) begin errors++; $display("FAIL ignore_start_counts got done %0d busy %0d want 1/17", dc, bc); end
    // Starts in the first IDLE cycle after done
    run_op(1'b0, 32'hDEAD_BEEF, 32'h0000_0003, -1, -1, '0, '0, lat, bc, dc, res, le);
    checks++; if (lat !== 16) begin errors++; $display("FAIL b2b_latency got %0d want 16", lat); end
    checks++; if (res !== ref_prod(32'hDEAD_BEEF, 32'h3)) begin errors++; $display("FAIL b2b_result got %h want %h", res, ref_prod(32'hDEAD_BEEF, 32'h3)); end
  endtask

  task automatic test_abort();
    int lat, bc, dc, le, late_done;
    logic [63:0] res;
    a = 32'hCAFE_F00D; b = 32'h1357_9BDF;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL abort_flags got busy %0b done %0b want 0/0", busy0, done0); end
    checks++; if (result0 !== 64'h0) begin errors++; $display("FAIL abort_result got %h want 0", result0); end
    @(negedge clk);
    rst = 1'b0;
    late_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done0 || busy0) late_done++;
    end
    checks++; if (late_done !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", late_done); end
    run_op(1'b0, 32'h89AB_CDEF, 32'h0246_8ACE, -1, -1, '0, '0, lat, bc, dc, res, le);
    checks++; if (res !== ref_prod(32'h89AB_CDEF, 32'h0246_8ACE)) begin errors++; $display("FAIL abort_fresh_result got %h want %h", res, ref_prod(32'h89AB_CDEF, 32'h0246_8ACE)); end
  endtask

  task automatic test_lat2();
    int lat, bc, dc, le;
    logic [63:0] res;
    run_op(1'b1, 32'd124, 32'd201, -1, -1, '0, '0, lat, bc, dc, res, le);
    checks++; if (lat !== 48) begin errors++; $display("FAIL lat2_latency got %0d want 48", lat); end
    checks++; if (res !== 64'd24924) begin errors++; $display("FAIL lat2_result got %h want %h", res, 64'd24924); end
    checks++; if (bc !== 49 || dc !== 1) begin errors++; $display("FAIL lat2_counts got busy %0d done %0d want 49/1", bc, dc); end
    checks++; if (le !== 0) begin errors++; $display("FAIL lat2_limb_drive got %0d bad cycles want 0", le); end
  endtask

  task automatic test_random();
    int lat, bc, dc, le;
    logic [63:0] res;
    logic [31:0] x, y;
    for (int t = 0; t < 14; t++) begin
      x = $urandom;
      y = $urandom;
      if (t % 5 == 4) x = x & 32'hFF00_00FF;
      run_op(t >= 11, x, y, -1, -1, '0, '0, lat, bc, dc, res, le);
      checks++;
      if (res !== ref_prod(x, y) || lat !== ((t >= 11) ? 48 : 16) || le !== 0) begin
        errors++;
        $display("FAIL random_%0d got %h lat %0d limberr %0d want %h lat %0d limberr 0",
                 t, res, lat, le, ref_prod(x, y), (t >= 11) ? 48 : 16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_abort();
    test_lat2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
